// File: rtl/sr_drive_encoder_if.sv
// ============================================================================
// Module      : sr_drive_encoder_if
// Description : Command/status bundle between a requester and sr_drive_encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sr_drive_encoder_if;
    logic en;
    logic d_in;
    logic refresh;
    logic s;
    logic r;
    logic q_track;
    logic busy;

    modport master (
        output en,
        output d_in,
        output refresh,
        input  s,
        input  r,
        input  q_track,
        input  busy
    );

    modport slave (
        input  en,
        input  d_in,
        input  refresh,
        output s,
        output r,
        output q_track,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/sr_drive_encoder.sv
// ============================================================================
// Module      : sr_drive_encoder
// Description : Turns a target level into width-controlled, non-overlapping
//               set/reset pulses for an S/R storage element.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_drive_encoder #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1,
    parameter int CNT_W   = 8
) (
    input  wire logic            clk,
    input  wire logic            rst,
    sr_drive_encoder_if.slave    bus
);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_SET_P = 3'd1,
        ST_RST_P = 3'd2,
        ST_GAP   = 3'd3,
        ST_IDLE  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_pulse_load = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] c_gap_load   = CNT_W'(GAP_W - 1);
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_s;
    logic             r_r;
    logic             r_q;
    logic             r_busy;

    // A new pulse is only considered in IDLE; refresh forces a re-drive.
    logic w_start;
    assign w_start = bus.en && ((bus.d_in != r_q) || bus.refresh);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_q     <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                // The latch content is unknown out of reset, so force it low.
                ST_INIT: begin
                    r_state <= ST_RST_P;
                    r_cnt   <= c_pulse_load;
                    r_s     <= 1'b0;
                    r_r     <= 1'b1;
                    r_busy  <= 1'b1;
                end
                ST_IDLE: begin
                    if (w_start) begin
                        r_cnt  <= c_pulse_load;
                        r_busy <= 1'b1;
                        if (bus.d_in) begin
                            r_state <= ST_SET_P;
                            r_s     <= 1'b1;
                            r_r     <= 1'b0;
                        end else begin
                            r_state <= ST_RST_P;
                            r_s     <= 1'b0;
                            r_r     <= 1'b1;
                        end
                    end else begin
                        r_s    <= 1'b0;
                        r_r    <= 1'b0;
                        r_busy <= 1'b0;
                    end
                end
                ST_SET_P, ST_RST_P: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_one;
                    end else begin
                        r_s     <= 1'b0;
                        r_r     <= 1'b0;
                        r_q     <= (r_state == ST_SET_P);
                        r_state <= ST_GAP;
                        r_cnt   <= c_gap_load;
                    end
                end
                ST_GAP: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_one;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= '0;
                    r_s     <= 1'b0;
                    r_r     <= 1'b0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.s       = r_s;
    assign bus.r       = r_r;
    assign bus.q_track = r_q;
    assign bus.busy    = r_busy;

endmodule

`default_nettype wire
